// File: rtl/reflet_float_to_int_seq.sv
// Multi-cycle float-to-integer converter with IEEE rounding modes, signed or
// unsigned targets, saturation, invalid/inexact flags and a serial right
// shifter that advances shift_step bits per cycle.
module reflet_float_to_int_seq #(
  parameter int int_size   = 16,
  parameter int float_size = 32,
  parameter int shift_step = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [float_size-1:0] float_in,
  input  logic [1:0]            round_mode,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [int_size-1:0]   int_out,
  output logic                  flag_invalid,
  output logic                  flag_inexact
);

  // Float format geometry (IEEE binary16/32/64/128 layouts).
  function automatic int exponent_size(input int fs);
    case (fs)
      16:      return 5;
      64:      return 11;
      128:     return 15;
      default: return 8;
    endcase
  endfunction

  function automatic int mantissa_size(input int fs);
    return fs - exponent_size(fs) - 1;
  endfunction

  function automatic int exponent_bias(input int fs);
    return (1 << (exponent_size(fs) - 1)) - 1;
  endfunction

  localparam int E_W  = exponent_size(float_size);
  localparam int M    = mantissa_size(float_size);
  localparam int BIAS = exponent_bias(float_size);
  localparam int QW   = ((int_size > M + 1) ? int_size : M + 1) + 1;
  localparam int NMAX = M + 2;
  localparam int CW   = $clog2(NMAX + 1);

  localparam logic [int_size-1:0] MAX_POS = {1'b0, {(int_size-1){1'b1}}};
  localparam logic [int_size-1:0] MIN_NEG = {1'b1, {(int_size-1){1'b0}}};
  localparam logic [QW-1:0]       LIM_POS = QW'(MAX_POS);
  localparam logic [QW-1:0]       LIM_NEG = QW'(MIN_NEG);
  localparam logic [QW-1:0]       LIM_U   = QW'({int_size{1'b1}});

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RUP, RM_RDN} rmode_t;

  state_t                state;
  rmode_t                rmode_r;
  logic                  sign_r;
  logic                  smode_r;
  logic [QW-1:0]         q_r;
  logic                  r_r;
  logic                  s_r;
  logic [CW-1:0]         rem_r;
  logic                  forced_r;
  logic [int_size-1:0]   forced_val_r;
  logic                  forced_inv_r;

  assign in_ready = (state == IDLE);

  // Saturation target for a given sign and target signedness.
  function automatic logic [int_size-1:0] sat_value(input logic neg, input logic smode);
    if (smode) return neg ? MIN_NEG : MAX_POS;
    if (neg) return '0;
    return '1;
  endfunction

  logic            sign_f;
  logic [E_W-1:0]  exp_f;
  logic [M-1:0]    mant_f;
  logic [M:0]      sig_f;
  int              x_int;

  assign sign_f = float_in[float_size-1];
  assign exp_f  = float_in[float_size-2 -: E_W];
  assign mant_f = float_in[M-1:0];
  assign sig_f  = {1'b1, mant_f};
  assign x_int  = int'(exp_f) - BIAS;

  logic                dec_forced;
  logic [int_size-1:0] dec_val;
  logic                dec_inv;
  logic [QW-1:0]       dec_q;
  logic [CW-1:0]       dec_n;

  // Operand decode: classify specials and preload the working register.
  always_comb begin
    dec_forced = 1'b0;
    dec_val    = '0;
    dec_inv    = 1'b0;
    dec_q      = '0;
    dec_n      = '0;
    if (exp_f == '0) begin
      dec_forced = 1'b1;
    end else if (exp_f == '1 && mant_f != '0) begin
      dec_forced = 1'b1;
      dec_inv    = 1'b1;
      dec_val    = signed_mode ? MAX_POS : '1;
    end else if (exp_f == '1 || x_int >= int_size) begin
      dec_forced = 1'b1;
      dec_inv    = 1'b1;
      dec_val    = sat_value(sign_f, signed_mode);
    end else if (x_int >= M) begin
      dec_q = QW'(sig_f) << (x_int - M);
    end else begin
      dec_q = QW'(sig_f);
      dec_n = CW'(((M - x_int) > NMAX) ? NMAX : (M - x_int));
    end
  end

  logic [CW-1:0] step;
  logic [CW-1:0] step_m1;
  logic [CW-1:0] rem_next;
  logic [QW-1:0] q_sh;
  logic [QW-1:0] low_mask;
  logic          r_sh;
  logic          s_sh;

  // One serial shift step; the last bit shifted out becomes the round bit,
  // everything below it (and the previous round bit) folds into sticky.
  always_comb begin
    step     = (rem_r < CW'(shift_step)) ? rem_r : CW'(shift_step);
    step_m1  = step - CW'(1);
    q_sh     = q_r >> step;
    low_mask = (QW'(1) << step_m1) - QW'(1);
    r_sh     = q_r[step_m1];
    s_sh     = s_r | r_r | (|(q_r & low_mask));
    rem_next = rem_r - step;
  end

  logic                inc;
  logic [QW-1:0]       r_mag;
  logic [int_size-1:0] res_val;
  logic                res_inv;
  logic                res_inex;

  // Rounding increment, range check and final sign application.
  always_comb begin
    case (rmode_r)
      RM_RNE:  inc = r_r & (s_r | q_r[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign_r & (r_r | s_r);
      default: inc = sign_r & (r_r | s_r);
    endcase
    r_mag    = q_r + QW'(inc);
    res_val  = '0;
    res_inv  = 1'b0;
    res_inex = 1'b0;
    if (forced_r) begin
      res_val = forced_val_r;
      res_inv = forced_inv_r;
    end else if (smode_r) begin
      if (!sign_r && r_mag > LIM_POS) begin
        res_val = MAX_POS;
        res_inv = 1'b1;
      end else if (sign_r && r_mag > LIM_NEG) begin
        res_val = MIN_NEG;
        res_inv = 1'b1;
      end else begin
        res_val  = sign_r ? -r_mag[int_size-1:0] : r_mag[int_size-1:0];
        res_inex = r_r | s_r;
      end
    end else begin
      if (sign_r && r_mag != '0) begin
        res_inv = 1'b1;
      end else if (sign_r) begin
        res_inex = r_r | s_r;
      end else if (r_mag > LIM_U) begin
        res_val = '1;
        res_inv = 1'b1;
      end else begin
        res_val  = r_mag[int_size-1:0];
        res_inex = r_r | s_r;
      end
    end
  end

  // Control FSM with registered result and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rmode_r      <= RM_RNE;
      sign_r       <= 1'b0;
      smode_r      <= 1'b0;
      q_r          <= '0;
      r_r          <= 1'b0;
      s_r          <= 1'b0;
      rem_r        <= '0;
      forced_r     <= 1'b0;
      forced_val_r <= '0;
      forced_inv_r <= 1'b0;
      out_valid    <= 1'b0;
      int_out      <= '0;
      flag_invalid <= 1'b0;
      flag_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rmode_r      <= rmode_t'(round_mode);
            sign_r       <= sign_f;
            smode_r      <= signed_mode;
            q_r          <= dec_q;
            r_r          <= 1'b0;
            s_r          <= 1'b0;
            rem_r        <= dec_n;
            forced_r     <= dec_forced;
            forced_val_r <= dec_val;
            forced_inv_r <= dec_inv;
            state        <= (dec_n != '0) ? SHIFT : ROUND;
          end
        end
        SHIFT: begin
          q_r   <= q_sh;
          r_r   <= r_sh;
          s_r   <= s_sh;
          rem_r <= rem_next;
          if (rem_next == '0) state <= ROUND;
        end
        ROUND: begin
          int_out      <= res_val;
          flag_invalid <= res_inv;
          flag_inexact <= res_inex;
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_float_to_int_seq.sv
// Scoreboard bench for reflet_float_to_int_seq: directed float vectors with
// hand-computed results, latency, handshake stall and asynchronous reset.
module tb_reflet_float_to_int_seq;

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_in;
  logic [1:0]  round_mode;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] int_out;
  logic        flag_invalid;
  logic        flag_inexact;

  reflet_float_to_int_seq #(
    .int_size  (16),
    .float_size(32),
    .shift_step(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .float_in    (float_in),
    .round_mode  (round_mode),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .int_out     (int_out),
    .flag_invalid(flag_invalid),
    .flag_inexact(flag_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        inv;
    logic        inex;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: compare each result as it is handed off.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h with no pending expectation", int_out);
        end else begin
          e = sb.pop_front();
          chk(e.name, {14'd0, int_out, flag_invalid, flag_inexact}, {14'd0, e.val, e.inv, e.inex});
        end
      end
    end
  end

  task automatic do_accept(input logic [31:0] f, input logic [1:0] rm, input logic sm,
                           input string name);
    bit ok = 1'b0;
    @(posedge clk); #2;
    float_in = f; round_mode = rm; signed_mode = sm; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got in_ready 0 expected 1", name);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; float_in = 32'hDEAD_BEEF; round_mode = ~rm; signed_mode = ~sm;
  endtask

  task automatic wait_valid(input string name, input int lat);
    int edges = 0;
    for (int i = 1; i <= 40 && edges == 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) edges = i;
    end
    if (edges == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no out_valid expected out_valid within 40 edges", name);
    end else begin
      chk({name, "_latency"}, edges, lat);
    end
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      done = !out_valid;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: got out_valid 1 expected 0", name);
    end
  endtask

  task automatic run(input string name, input logic [31:0] f, input logic [1:0] rm,
                     input logic sm, input logic [15:0] val, input logic inv,
                     input logic inex, input int lat);
    sb.push_back('{val, inv, inex, name});
    do_accept(f, rm, sm, name);
    wait_valid(name, lat);
    drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    float_in = '0; round_mode = RNE; signed_mode = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; #1;
    chk("reset_state", {15'd0, out_valid, int_out, flag_invalid, flag_inexact, in_ready},
        {15'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});

    // name, float, mode, signed, value, invalid, inexact, latency
    run("pi_rne",        32'h40490FDB, RNE, 1'b1, 16'h0003, 1'b0, 1'b1, 7);
    run("p2_5_rne",      32'h40200000, RNE, 1'b1, 16'h0002, 1'b0, 1'b1, 7);
    run("p2_5_rup",      32'h40200000, RUP, 1'b1, 16'h0003, 1'b0, 1'b1, 7);
    run("m2_5_rdn",      32'hC0200000, RDN, 1'b1, 16'hFFFD, 1'b0, 1'b1, 7);
    run("p1_5_rne",      32'h3FC00000, RNE, 1'b1, 16'h0002, 1'b0, 1'b1, 7);
    run("p1_0",          32'h3F800000, RNE, 1'b1, 16'h0001, 1'b0, 1'b0, 7);
    run("m1_0",          32'hBF800000, RNE, 1'b1, 16'hFFFF, 1'b0, 1'b0, 7);
    run("p100",          32'h42C80000, RTZ, 1'b1, 16'h0064, 1'b0, 1'b0, 6);
    run("min_normal_up", 32'h00800000, RUP, 1'b1, 16'h0001, 1'b0, 1'b1, 8);
    run("u65535",        32'h477FFF00, RNE, 1'b0, 16'hFFFF, 1'b0, 1'b0, 3);
    run("u65536",        32'h47800000, RNE, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1);
    run("s65536",        32'h47800000, RNE, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1);
    run("s_m32768",      32'hC7000000, RNE, 1'b1, 16'h8000, 1'b0, 1'b0, 3);
    run("s_m32769",      32'hC7000100, RNE, 1'b1, 16'h8000, 1'b1, 1'b0, 3);
    run("s_32767_5_rne", 32'h46FFFF00, RNE, 1'b1, 16'h7FFF, 1'b1, 1'b0, 4);
    run("nan",           32'h7FC00000, RNE, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1);
    run("nan_unsigned",  32'h7FC00000, RNE, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1);
    run("subnormal",     32'h00000001, RNE, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
    run("u_m0_75_rdn",   32'hBF400000, RDN, 1'b0, 16'h0000, 1'b1, 1'b0, 7);
    run("u_m0_75_rtz",   32'hBF400000, RTZ, 1'b0, 16'h0000, 1'b0, 1'b1, 7);
    run("neg_inf",       32'hFF800000, RNE, 1'b1, 16'h8000, 1'b1, 1'b0, 1);

    // Async reset in the middle of a shift sequence.
    do_accept(32'h40490FDB, RNE, 1'b1, "rst_req");
    @(posedge clk); #2;
    chk("pre_reset_outputs", {14'd0, out_valid, int_out, flag_invalid, flag_inexact},
        {14'd0, 1'b0, 16'h8000, 1'b1, 1'b0});
    reset = 1'b1; #1;
    chk("reset_async", {14'd0, out_valid, int_out, flag_invalid, flag_inexact}, 32'd0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    run("after_reset",   32'h3F800000, RNE, 1'b1, 16'h0001, 1'b0, 1'b0, 7);

    // Consumer stall: result held, new request blocked until DONE exits.
    out_ready = 1'b0;
    sb.push_back('{16'h0064, 1'b0, 1'b0, "hold_a"});
    do_accept(32'h42C80000, RNE, 1'b1, "hold_a");
    wait_valid("hold_a", 6);
    float_in = 32'h40200000; round_mode = RUP; signed_mode = 1'b1; in_valid = 1'b1;
    sb.push_back('{16'h0003, 1'b0, 1'b1, "hold_b"});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_stable", {13'd0, out_valid, int_out, flag_invalid, flag_inexact, in_ready},
          {13'd0, 1'b1, 16'h0064, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    do_accept(32'h40200000, RUP, 1'b1, "hold_b");
    wait_valid("hold_b", 7);
    drain("hold_b");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
